// File: rtl/riscv_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package riscv_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFetch,
    StFlush
  } fetch_state_t;

  // Canonical NOP (addi x0, x0, 0).
  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam int unsigned PC_INCR   = 4;

endpackage

// File: rtl/riscv_fetch_unit_if.sv
// Instruction-memory request/response and core-side valid/ready signals.
interface riscv_fetch_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  imem_req_o;
  logic [DATA_WIDTH-1:0] imem_addr_o;
  logic                  imem_gnt_i;
  logic                  imem_rvalid_i;
  logic [DATA_WIDTH-1:0] imem_rdata_i;
  logic                  instr_valid_o;
  logic [DATA_WIDTH-1:0] instr_o;
  logic [DATA_WIDTH-1:0] instr_pc_o;
  logic                  instr_ready_i;

  // Fetch unit side.
  modport master (
    output imem_req_o, imem_addr_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    output instr_valid_o, instr_o, instr_pc_o,
    input  instr_ready_i
  );

  // Memory / core side.
  modport slave (
    input  imem_req_o, imem_addr_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
    input  instr_valid_o, instr_o, instr_pc_o,
    output instr_ready_i
  );

endinterface

// File: rtl/riscv_fetch_unit_fifo.sv
// Small synchronous FIFO; a pop on a full FIFO frees the slot for a same-cycle push.
module riscv_fetch_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             push_ok, pop_ok;

  assign pop_ok  = pop_i && (count_q != '0);
  assign push_ok = push_i && ((count_q != FullCount) || pop_ok);

  // Pointer and occupancy bookkeeping; flush empties without touching storage.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      count_q <= count_q + CntW'(push_ok) - CntW'(pop_ok);
    end
  end

  // Storage write.
  always_ff @(posedge clk) begin
    if (push_ok && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/riscv_fetch_unit.sv
// Instruction fetch stage: credit-limited sequential fetch, prefetch buffer, redirect flush.
module riscv_fetch_unit
  import riscv_fetch_unit_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned           FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  riscv_fetch_unit_if.master    bus,
  input  logic                  redirect_i,
  input  logic [DATA_WIDTH-1:0] redirect_pc_i,
  output logic                  busy_o
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SumW = CntW + 1;

  fetch_state_t            state_q, state_d;
  logic [DATA_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]         outstanding_q, outstanding_d;
  logic [CntW-1:0]         discard_q, discard_d;
  logic [CntW-1:0]         buf_count, tag_count;
  logic [DATA_WIDTH-1:0]   tag_pc;
  logic [2*DATA_WIDTH-1:0] buf_head;
  logic [SumW-1:0]         credit_used;
  logic                    req, gnt_fire, rv_fire, buf_push, buf_pop, credit_ok, instr_valid;
  logic                    unused_redirect_lsb;

  assign unused_redirect_lsb = ^redirect_pc_i[1:0];

  // Tag queue holds one entry per issued-but-unanswered request, discards included,
  // so its count plus the buffer count is the total credit in use.
  assign credit_used = SumW'(buf_count) + SumW'(tag_count);
  assign credit_ok   = credit_used < SumW'(FIFO_DEPTH);
  assign gnt_fire    = req & bus.imem_gnt_i;
  // Responses with nothing pending (e.g. stragglers from before reset) are ignored.
  assign rv_fire     = bus.imem_rvalid_i & (tag_count != '0);
  assign buf_push    = rv_fire & (discard_q == '0) & ~redirect_i;
  assign instr_valid = (buf_count != '0);
  assign buf_pop     = instr_valid & bus.instr_ready_i;

  riscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_tag_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (1'b0),
    .push_i  (gnt_fire),
    .data_i  (fetch_pc_q),
    .pop_i   (rv_fire),
    .data_o  (tag_pc),
    .count_o (tag_count)
  );

  riscv_fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2 * DATA_WIDTH)
  ) u_prefetch_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (redirect_i),
    .push_i  (buf_push),
    .data_i  ({tag_pc, bus.imem_rdata_i}),
    .pop_i   (buf_pop),
    .data_o  (buf_head),
    .count_o (buf_count)
  );

  // Next fetch PC and request/discard counters.
  always_comb begin
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fetch_pc_d    = fetch_pc_q;
    if (redirect_i) begin
      // Everything still in flight (minus a response landing now) becomes a discard.
      discard_d     = discard_q + outstanding_q - CntW'(rv_fire);
      outstanding_d = '0;
      fetch_pc_d    = {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
    end else begin
      if (rv_fire && (discard_q != '0)) discard_d = discard_q - CntW'(1);
      outstanding_d = outstanding_q + CntW'(gnt_fire) - CntW'(rv_fire && (discard_q == '0));
      if (gnt_fire) fetch_pc_d = fetch_pc_q + DATA_WIDTH'(PC_INCR);
    end
  end

  // FSM next state: FLUSH while any discards remain.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:           state_d = StFetch;
      StFetch, StFlush: state_d = (discard_d != '0) ? StFlush : StFetch;
      default:          state_d = StIdle;
    endcase
  end

  // FSM output: request whenever credit allows, never in a redirect cycle.
  always_comb begin
    req = (state_q != StIdle) && !redirect_i && credit_ok;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  assign bus.imem_req_o    = req;
  assign bus.imem_addr_o   = fetch_pc_q;
  assign bus.instr_valid_o = instr_valid;
  assign bus.instr_o       = instr_valid ? buf_head[DATA_WIDTH-1:0] : '0;
  assign bus.instr_pc_o    = instr_valid ? buf_head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
  assign busy_o            = (outstanding_q != '0) || (discard_q != '0);

endmodule

// File: doc/riscv_fetch_unit.md
Name: riscv_fetch_unit

Overview:
Instruction fetch stage directly upstream of riscv_core's decode/execute path. It generates sequential fetch addresses and issues requests to instruction memory over a req/gnt/rvalid handshake. Returned words are buffered in a small in-order prefetch FIFO and handed to the core through a valid/ready interface. On a branch or jump redirect it flushes the FIFO and discards in-flight responses.

Parameters:
DATA_WIDTH, 32, instruction/address width
RESET_PC, 32'h0000_0000, first fetch address after reset
FIFO_DEPTH, 4, prefetch entries; power of two, >= 2; also caps total in-flight requests

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
imem_req_o  out  1  fetch request
imem_addr_o  out  DATA_WIDTH  fetch address, word aligned
imem_gnt_i  in  1  request accepted this cycle
imem_rvalid_i  in  1  response valid; in-order, >= 1 cycle after gnt
imem_rdata_i  in  DATA_WIDTH  response instruction word
redirect_i  in  1  branch/jump taken; 1-cycle pulse
redirect_pc_i  in  DATA_WIDTH  new fetch target; bits[1:0] ignored
instr_valid_o  out  1  FIFO head valid
instr_o  out  DATA_WIDTH  head instruction
instr_pc_o  out  DATA_WIDTH  PC of head instruction
instr_ready_i  in  1  core consumes head when valid&ready
busy_o  out  1  outstanding requests or discards pending

Behaviour:
- Reset (rst_n=0 at posedge): fetch_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; state=IDLE. Outputs: imem_req_o=0, imem_addr_o=RESET_PC, instr_valid_o=0, instr_o=0, instr_pc_o=0, busy_o=0. Reset mid-transaction drops everything; late rvalids after reset count as discards only if discard>0, otherwise ignored.
- States: IDLE -> FETCH on the first cycle with rst_n=1. FETCH -> FLUSH on redirect_i when outstanding>0 (excluding any response accepted that same cycle). FLUSH -> FETCH when discard reaches 0. FETCH stays in FETCH on redirect with outstanding=0.
- Credit rule: imem_req_o=1 in FETCH iff fifo_count + outstanding < FIFO_DEPTH and redirect_i=0. In FLUSH, requests to the new PC are allowed under the same rule; discards occupy credit until drained.
- imem_addr_o=fetch_pc, held stable while req=1 and gnt=0, except on redirect.
- On req&gnt: fetch_pc += 4 (wraps modulo 2^DATA_WIDTH); outstanding++; the issued PC is pushed into a PC tag queue of depth FIFO_DEPTH.
- On rvalid with discard>0: discard--, data dropped, tag popped. Otherwise the word and popped tag are written to the FIFO and outstanding--.
- Simultaneous gnt and rvalid: outstanding unchanged. Simultaneous FIFO push and pop are both honoured, including when the FIFO is full (pop frees the slot).
- Redirect (cycle N): FIFO cleared; discard=outstanding (after applying cycle-N gnt/rvalid updates); outstanding=0; fetch_pc={redirect_pc_i[31:2],2'b00}; imem_req_o=0 in cycle N. The first request to the new PC is issued in cycle N+1. An rvalid in cycle N is dropped. instr_valid_o=0 in cycle N+1.
- Fetch-to-use latency: gnt at cycle T, rvalid at T+1, instr_valid_o=1 at T+2 (FIFO registered, no bypass).
- instr_o/instr_pc_o are stable while valid&!ready.
- busy_o = (outstanding != 0) | (discard != 0).
- Illegal-condition assertions (bench): rvalid while outstanding+discard==0; redirect_i high for 2 consecutive cycles.

Decomposition:
- riscv_pkg additions: FETCH_STATE_T enum {IDLE, FETCH, FLUSH}; INSTR_NOP=32'h0000_0013; PC_INCR=4.
- Sub-module riscv_fetch_fifo (parameterised sync FIFO, DEPTH/WIDTH, push/pop/flush/count). Instantiated twice: the {pc, instr} prefetch buffer and the PC tag queue.

Test Plan:
- Reset, 1-cycle-latency memory, ready=1 -> addrs 0x00,0x04,0x08...; first instr_valid_o 2 cycles after first gnt; instr_pc_o sequence matches.
- Hold instr_ready_i=0 for 10 cycles -> exactly FIFO_DEPTH=4 words buffered, req drops to 0, no overflow; release -> PCs 0x00..0x0C drain in order.
- gnt withheld 3 cycles -> imem_req_o and imem_addr_o=0x10 held stable; single increment after gnt.
- Redirect to 0x103 with 2 outstanding -> next addr 0x100, state FLUSH, 2 rvalids dropped, first delivered instr_pc_o=0x100, busy_o=0 after drain.
- fetch_pc=0xFFFF_FFFC granted -> next addr 0x0000_0000.
- rst_n=0 with 3 outstanding and full FIFO -> next cycle all outputs at reset values; fetch restarts at RESET_PC.
